// File: rtl/wb_tlc_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding, CTI codes,
// default bus widths and the watchdog counter width helper.
package wb_tlc_pkg;

    localparam int unsigned WB_AW   = 32;
    localparam int unsigned WB_DW   = 16;
    localparam int unsigned WB_CTIW = 3;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [WB_CTIW-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [WB_CTIW-1:0] CTI_INCR    = 3'b010;
    localparam logic [WB_CTIW-1:0] CTI_EOB     = 3'b111;

    // Watchdog counter width: wide enough for the limit, clamped to 8..16 bits.
    function automatic int unsigned wdog_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        if (w < 8)  w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/wb_tlc_arb_if.sv
// One Wishbone link (request + response) with master/slave views.
interface wb_tlc_arb_if #(
    parameter int unsigned AW = wb_tlc_pkg::WB_AW,
    parameter int unsigned DW = wb_tlc_pkg::WB_DW
) ();
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [2:0]      cti;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            stb;
    logic            cyc;
    logic            lock;
    logic            ack;
    logic            err;

    modport master (
        output adr, dat_w, cti, sel, we, stb, cyc, lock,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, cti, sel, we, stb, cyc, lock,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_tlc_arb_wdog.sv
// Stalled-strobe watchdog: counts cycles with strobe high and no ack, and flags the
// cycle on which the stall reaches TIMEOUT_CYC.
module wb_tlc_arb_wdog
    import wb_tlc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic wb_clk,
    input  logic rstn,
    input  logic i_stall,
    input  logic i_clr,
    output logic o_timeout_c
);
    localparam int unsigned CW = wdog_width(TIMEOUT_CYC);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge wb_clk or negedge rstn) begin
        if (!rstn)        r_cnt <= '0;
        else if (i_clr)   r_cnt <= '0;
        else if (i_stall) r_cnt <= r_cnt + CW'(1);
    end

    // The current stalled cycle is the TIMEOUT_CYC-th one.
    assign o_timeout_c = i_stall & (r_cnt == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/wb_tlc_arb.sv
// Two-master round-robin Wishbone arbiter (PCIe TLC master 0, local/DMA master 1).
// Optional stalled-strobe timeout is built when WB_ARB_TIMEOUT_EN is defined.
module wb_tlc_arb
    import wb_tlc_pkg::*;
#(
    parameter int unsigned AW          = WB_AW,
    parameter int unsigned DW          = WB_DW,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                wb_clk,
    input  logic                rstn,
    wb_tlc_arb_if.slave         m0,
    wb_tlc_arb_if.slave         m1,
    wb_tlc_arb_if.master        s,
    output logic [1:0]          arb_state
);
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("wb_tlc_arb: TIMEOUT_CYC out of range");
    end

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_last_gnt;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_timeout;

    logic [AW-1:0]   w_adr;
    logic [DW-1:0]   w_dat;
    logic [2:0]      w_cti;
    logic [DW/8-1:0] w_sel;
    logic            w_we;
    logic            w_stb;
    logic            w_cyc;
    logic            w_lock;

    assign w_gnt0 = (r_state == ARB_GNT0);
    assign w_gnt1 = (r_state == ARB_GNT1);

    // State register; last_gnt records whoever was most recently granted.
    always_ff @(posedge wb_clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ARB_IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ARB_GNT0)      r_last_gnt <= 1'b0;
            else if (w_state_nxt == ARB_GNT1) r_last_gnt <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB_IDLE: begin
                if (m0.cyc && m1.cyc) w_state_nxt = r_last_gnt ? ARB_GNT0 : ARB_GNT1;
                else if (m0.cyc)      w_state_nxt = ARB_GNT0;
                else if (m1.cyc)      w_state_nxt = ARB_GNT1;
            end
            ARB_GNT0: begin
                if (!(m0.cyc || m0.lock)) w_state_nxt = m1.cyc ? ARB_GNT1 : ARB_IDLE;
            end
            ARB_GNT1: begin
                if (!(m1.cyc || m1.lock)) w_state_nxt = m0.cyc ? ARB_GNT0 : ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
        if (w_timeout) w_state_nxt = ARB_IDLE;
    end

    // Slave request mux: all zero while idle.
    always_comb begin
        w_adr  = '0;
        w_dat  = '0;
        w_cti  = '0;
        w_sel  = '0;
        w_we   = 1'b0;
        w_stb  = 1'b0;
        w_cyc  = 1'b0;
        w_lock = 1'b0;
        if (w_gnt0) begin
            w_adr  = m0.adr;
            w_dat  = m0.dat_w;
            w_cti  = m0.cti;
            w_sel  = m0.sel;
            w_we   = m0.we;
            w_stb  = m0.stb;
            w_cyc  = m0.cyc;
            w_lock = m0.lock;
        end else if (w_gnt1) begin
            w_adr  = m1.adr;
            w_dat  = m1.dat_w;
            w_cti  = m1.cti;
            w_sel  = m1.sel;
            w_we   = m1.we;
            w_stb  = m1.stb;
            w_cyc  = m1.cyc;
            w_lock = m1.lock;
        end
    end

    assign s.adr   = w_adr;
    assign s.dat_w = w_dat;
    assign s.cti   = w_cti;
    assign s.sel   = w_sel;
    assign s.we    = w_we;
    assign s.stb   = w_stb;
    assign s.cyc   = w_cyc;
    assign s.lock  = w_lock;

    assign m0.ack   = s.ack & w_gnt0 & m0.stb;
    assign m1.ack   = s.ack & w_gnt1 & m1.stb;
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;
    assign arb_state = r_state;

`ifdef WB_ARB_TIMEOUT_EN
    logic r_err0;
    logic r_err1;

    wb_tlc_arb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .wb_clk      (wb_clk),
        .rstn        (rstn),
        .i_stall     (w_stb & ~s.ack),
        .i_clr       (s.ack | (w_state_nxt != r_state)),
        .o_timeout_c (w_timeout)
    );

    // Error pulse lands on the same edge that forces the FSM back to idle.
    always_ff @(posedge wb_clk or negedge rstn) begin
        if (!rstn) begin
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            r_err0 <= w_timeout & w_gnt0;
            r_err1 <= w_timeout & w_gnt1;
        end
    end

    assign m0.err = r_err0;
    assign m1.err = r_err1;
`else
    assign w_timeout = 1'b0;
    assign m0.err    = 1'b0;
    assign m1.err    = 1'b0;
`endif
endmodule
